keypad_emulator: RTL and testbench

Drives the row lines of a 4x4 matrix keypad in response to column scanning, so the keypad scanner, decoder and downstream calculator logic can be exercised without a physical pad. Accepts one key-press command at a time over a valid/ready handshake. For each command it holds the key closed for a fixed time, then opens it for a fixed gap. It sits between a command source (testbench, UART, or self-test ROM) and the scanner's `row`/`col` pins.

---
 rtl/keypad_emulator.sv | 132 +++++++++++++
 tb/tb_keypad_emulator.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_emulator.sv
// 4x4 matrix keypad emulator: presses one commanded key for HOLD_CYCLES, then releases it for GAP_CYCLES.
// Define KEYPAD_EMU_BOUNCE_EN to add contact bounce at the start of each press and release.
module keypad_emulator #(
    parameter int HOLD_CYCLES = 400000,
    parameter int GAP_CYCLES  = 200000,
    parameter int BOUNCE_TOG  = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_code,
    input  logic       key_valid,
    output logic       key_ready,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic       pressed,
    output logic [7:0] press_count
);
    localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PRESS   = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    logic [1:0]    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [3:0]    key_q;
    logic [3:0]    rc;
    logic [3:0]    row_nxt;
    logic          contact_nxt;
    logic          accept;

    // Key position as {row, column}, column 0 leftmost.
    function automatic logic [3:0] key_pos(input logic [3:0] code);
        case (code)
            4'h1: key_pos = 4'b00_00;
            4'h2: key_pos = 4'b00_01;
            4'h3: key_pos = 4'b00_10;
            4'hA: key_pos = 4'b00_11;
            4'h4: key_pos = 4'b01_00;
            4'h5: key_pos = 4'b01_01;
            4'h6: key_pos = 4'b01_10;
            4'hB: key_pos = 4'b01_11;
            4'h7: key_pos = 4'b10_00;
            4'h8: key_pos = 4'b10_01;
            4'h9: key_pos = 4'b10_10;
            4'hC: key_pos = 4'b10_11;
            4'h0: key_pos = 4'b11_00;
            4'hF: key_pos = 4'b11_01;
            4'hE: key_pos = 4'b11_10;
            default: key_pos = 4'b11_11;
        endcase
    endfunction

`ifdef KEYPAD_EMU_BOUNCE_EN
    // True in the second and fourth toggle periods of a bounce window.
    function automatic logic bounce_flip(input int k);
        bounce_flip = ((k >= BOUNCE_TOG) && (k < 2 * BOUNCE_TOG)) ||
                      ((k >= 3 * BOUNCE_TOG) && (k < 4 * BOUNCE_TOG));
    endfunction
`endif

    assign key_ready = (state == ST_IDLE);
    assign accept    = key_valid && key_ready;
    assign rc        = key_pos(key_q);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (accept) state_nxt = ST_PRESS;
            end
            ST_PRESS: begin
                if (cnt == CW'(HOLD_CYCLES - 1)) begin
                    state_nxt = ST_RELEASE;
                    cnt_nxt   = '0;
                end
            end
            ST_RELEASE: begin
                if (cnt == CW'(GAP_CYCLES - 1)) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Contact state for the coming cycle, so `pressed` tracks the state register exactly.
    always_comb begin
`ifdef KEYPAD_EMU_BOUNCE_EN
        if (state_nxt == ST_PRESS)
            contact_nxt = !bounce_flip(int'(cnt_nxt));
        else if (state_nxt == ST_RELEASE)
            contact_nxt = bounce_flip(int'(cnt_nxt));
        else
            contact_nxt = 1'b0;
`else
        contact_nxt = (state_nxt == ST_PRESS);
`endif
    end

    // A closed switch shorts its row to its column whenever that column is driven low.
    always_comb begin
        row_nxt = 4'hF;
        if (pressed && !col[rc[1:0]]) row_nxt[rc[3:2]] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            key_q       <= 4'h0;
            row         <= 4'hF;
            pressed     <= 1'b0;
            press_count <= 8'd0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            row     <= row_nxt;
            pressed <= contact_nxt;
            if (accept) key_q <= key_code;
            if ((state == ST_RELEASE) && (state_nxt == ST_IDLE))
                press_count <= press_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: directed steps plus random traffic against a timeline-based reference model.
module tb_keypad_emulator;
    localparam int H  = 20;
    localparam int G  = 10;
    localparam int BT = 2;

    localparam logic [3:0] KEYMAP [0:15] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'h0, 4'hF, 4'hE, 4'hD
    };

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic [3:0] col;
    logic [3:0] row;
    logic       pressed;
    logic [7:0] press_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: a press is described only by its age in cycles since accept.
    bit         m_busy    = 1'b0;
    int         m_age     = 0;
    logic [3:0] m_code    = 4'h0;
    int         m_count   = 0;
    logic       m_pressed = 1'b0;
    logic [3:0] m_row     = 4'hF;

    always #5 clk = ~clk;

    keypad_emulator #(
        .HOLD_CYCLES(H),
        .GAP_CYCLES (G),
        .BOUNCE_TOG (BT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .col        (col),
        .row        (row),
        .pressed    (pressed),
        .press_count(press_count)
    );

    function automatic int keypos(input logic [3:0] code);
        for (int i = 0; i < 16; i++)
            if (KEYMAP[i] == code) return i;
        return 0;
    endfunction

    function automatic bit m_contact(input int age);
        int k;
        if (age >= 1 && age <= H) begin
            k = age - 1;
`ifdef KEYPAD_EMU_BOUNCE_EN
            if (k < 4 * BT) return ((k / BT) % 2) == 0;
`endif
            return 1'b1;
        end else if (age > H && age <= H + G) begin
            k = age - H - 1;
`ifdef KEYPAD_EMU_BOUNCE_EN
            if (k < 4 * BT) return ((k / BT) % 2) == 1;
`endif
            return 1'b0;
        end
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, expv);
        end
    endtask

    // Advance the model with the inputs present before the edge, clock once, compare all outputs.
    task automatic step();
        logic [3:0] nrow;
        int pos;
        nrow = 4'hF;
        if (m_pressed) begin
            pos = keypos(m_code);
            if (!col[pos % 4]) nrow[pos / 4] = 1'b0;
        end
        if (!rst_n) begin
            m_busy = 1'b0; m_age = 0; m_code = 4'h0; m_count = 0;
            m_pressed = 1'b0; m_row = 4'hF;
        end else begin
            m_row = nrow;
            if (!m_busy) begin
                if (key_valid) begin
                    m_busy = 1'b1; m_age = 1; m_code = key_code;
                end
            end else begin
                m_age++;
                if (m_age == H + G + 1) begin
                    m_busy  = 1'b0;
                    m_count = (m_count + 1) % 256;
                end
            end
            m_pressed = m_busy && m_contact(m_age);
        end
        @(posedge clk);
        #1;
        cyc++;
        check("row", {4'h0, row}, {4'h0, m_row});
        check("pressed", {7'd0, pressed}, {7'd0, m_pressed});
        check("key_ready", {7'd0, key_ready}, {7'd0, !m_busy});
        check("press_count", press_count, m_count[7:0]);
    endtask

    initial begin
        int n;
        int saved;
        rst_n = 1'b0; key_valid = 1'b0; key_code = 4'h0; col = 4'hF;
        step(); step();
        rst_n = 1'b1;
        step();
        check("reset_row", {4'h0, row}, 8'h0F);
        check("reset_ready", {7'd0, key_ready}, 8'd1);
        check("reset_count", press_count, 8'd0);

        // Reset in the middle of a press.
        saved = m_count;
        key_code = 4'h5; key_valid = 1'b1; col = 4'b1101;
        step();
        key_valid = 1'b0;
        repeat (4) step();
        rst_n = 1'b0;
        step();
        check("midrst_row", {4'h0, row}, 8'h0F);
        check("midrst_pressed", {7'd0, pressed}, 8'd0);
        check("midrst_ready", {7'd0, key_ready}, 8'd1);
        check("midrst_count", press_count, saved[7:0]);
        rst_n = 1'b1;
        step();

        // Key 6 with the columns scanned one per cycle.
        key_code = 4'h6; key_valid = 1'b1; col = 4'b1110;
        step();
        key_valid = 1'b0;
        n = 1;
        while (!key_ready && n < 60) begin
            col = ~(4'b0001 << (n % 4));
            step();
            n++;
        end
        check("ready_latency_6", n[7:0], 8'd31);
        check("count_after_6", press_count, 8'd1);

        // Key D with every column driven low.
        key_code = 4'hD; key_valid = 1'b1; col = 4'b0000;
        step();
        key_valid = 1'b0;
        n = 1;
        while (!key_ready && n < 60) begin
            step();
            n++;
        end
        check("ready_latency_D", n[7:0], 8'd31);

        // Back-to-back with valid held high.
        key_code = 4'h0; key_valid = 1'b1; col = 4'b1110;
        step();
        key_code = 4'hA;
        n = 0;
        while (!key_ready && n < 60) begin
            step();
            n++;
        end
        check("b2b_gap", 8'(n + 1), 8'd31);
        step();
        key_valid = 1'b0;
        check("b2b_second_busy", {7'd0, key_ready}, 8'd0);
        n = 1;
        while (!key_ready && n < 60) begin
            step();
            n++;
        end
        check("b2b_latency", n[7:0], 8'd31);

`ifdef KEYPAD_EMU_BOUNCE_EN
        begin
            logic [7:0] seq;
            seq = 8'b0011_0011;
            key_code = 4'h1; key_valid = 1'b1; col = 4'b1110;
            step();
            key_valid = 1'b0;
            for (int i = 0; i < 8; i++) begin
                check("bounce_press", {7'd0, pressed}, {7'd0, seq[i]});
                step();
            end
            while (!key_ready && n < 200) begin
                step();
                n++;
            end
        end
`endif

        // Random traffic long enough to wrap press_count.
        for (int i = 0; i < 8400; i++) begin
            key_valid = ($urandom_range(0, 3) != 0);
            key_code  = 4'($urandom_range(0, 15));
            col       = 4'($urandom_range(0, 15));
            step();
        end

        // Random traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            rst_n     = ($urandom_range(0, 150) != 0);
            key_valid = ($urandom_range(0, 1) != 0);
            key_code  = 4'($urandom_range(0, 15));
            col       = 4'($urandom_range(0, 15));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
